// File: rtl/handshake_rx_pkg.sv
// Shared audio definitions: default sample width, handshake FSM states and
// the occupancy-counter width helper.
package handshake_rx_pkg;
  localparam int WIDTH_DEF = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  // An occupancy count for a FIFO of 'depth' entries must also represent 'depth' itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/handshake_rx_if.sv
// Receive-side bus: 4-phase req/ack from the transmit domain plus the
// valid/ready sample stream toward the audio consumer.
interface handshake_rx_if
  import handshake_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
);
  logic                      Req;
  logic [WIDTH-1:0]          din;
  logic                      Ack;
  logic [WIDTH-1:0]          sample;
  logic                      sample_valid;
  logic                      sample_ready;
  logic [lvl_w(DEPTH)-1:0]   level;

  // master: transmitter and consumer side; slave: the receiver block
  modport master (output Req, din, sample_ready,
                  input  Ack, sample, sample_valid, level);
  modport slave  (input  Req, din, sample_ready,
                  output Ack, sample, sample_valid, level);
endinterface

// File: rtl/handshake_rx_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; reusable by other
// audio paths. rd_data reads zero while empty.
module fifo_fwft #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers wrap naturally modulo 2*DEPTH thanks to the extra MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/handshake_rx.sv
// Receive side of the 4-phase req/ack CDC for audio samples: synchronises
// Req, captures the held din once, returns Ack and buffers into a FWFT FIFO.
module handshake_rx
  import handshake_rx_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  handshake_rx_if.slave    bus
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  state_t                 state;
  logic                   ack;
  logic                   wr_en;
  logic                   full;
  logic                   empty;

  // Req is asynchronous to clk; din is never synchronised because it is
  // only sampled once req_s shows it has been stable for the whole chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], bus.Req};
  end
  assign req_s = sync[SYNC_STAGES-1];

  // Full comes from registered pointers, so a same-cycle pop never admits a
  // push into a full buffer; the capture simply happens one cycle later.
  assign wr_en = (state == IDLE) && req_s && !full;

  // One write per Req high phase; Ack is a flop so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s && !full) begin
            state <= ACKED;
            ack   <= 1'b1;
          end
        end
        ACKED: begin
          if (!req_s) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ack          = ack;
  assign bus.sample_valid = !empty;

  fifo_fwft #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.din),
    .rd_en   (bus.sample_ready),
    .rd_data (bus.sample),
    .empty   (empty),
    .full    (full),
    .level   (bus.level)
  );
endmodule

// File: tb/tb_handshake_rx.sv
// Randomised bench for handshake_rx: a 4-phase transmitter model feeds words,
// expected words go into a scoreboard queue, and a monitor pops and compares
// every sample the consumer accepts.
module tb_handshake_rx;
  localparam int W = 12;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_rx_if #(.WIDTH(W), .DEPTH(D)) bus ();

  handshake_rx #(.WIDTH(W), .SYNC_STAGES(2), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int max_lvl = 0;
  logic [W-1:0] exp_q[$];

  // consumer ready: forced high, or a 1-of-3 duty pattern
  logic rdy_force = 1'b0;
  logic rdy_mode  = 1'b0;
  int   ph = 0;
  always @(posedge clk) ph <= (ph == 2) ? 0 : ph + 1;
  assign bus.sample_ready = rdy_force | (rdy_mode & (ph == 0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bounded wait for Ack to reach a value; an expired bound is a failure
  task automatic wait_ack(input logic val, input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      if (bus.Ack === val) break;
      tick(1);
    end
    chk(name, {31'd0, bus.Ack}, {31'd0, val});
  endtask

  // full 4-phase handshake for one word, with random gaps
  task automatic send_word(input logic [W-1:0] w, input bit rnd);
    wait_ack(1'b0, 50, "ack_idle");
    if (rnd) tick($urandom_range(0, 3));
    bus.din = w;
    bus.Req = 1'b1;
    exp_q.push_back(w);
    wait_ack(1'b1, 200, "ack_rise");
    if (rnd) tick($urandom_range(0, 3));
    bus.Req = 1'b0;
    wait_ack(1'b0, 50, "ack_fall");
  endtask

  task automatic drain();
    int k;
    rdy_force = 1'b1;
    for (k = 0; k < 100 && (exp_q.size() != 0 || bus.sample_valid); k++) tick(1);
    chk("drain_empty", exp_q.size(), 0);
    rdy_force = 1'b0;
  endtask

  // monitor: every accepted sample must be the oldest expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      chk("valid_vs_level", {31'd0, bus.sample_valid}, {31'd0, bus.level != 0});
      if (bus.level > D) chk("level_bound", bus.level, D);
      if (bus.sample_valid && bus.sample_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("unexpected_sample", bus.sample, 32'hDEAD);
        else chk("sample_order", bus.sample, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [W-1:0] w;
    bus.Req = 1'b0;
    bus.din = '0;
    tick(3);
    chk("rst_ack", bus.Ack, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_sample", bus.sample, 0);
    rst = 1'b0;
    tick(2);

    // single transfer with exact latencies
    rdy_force = 1'b1;
    p0 = pops;
    bus.din = 12'hA5C;
    bus.Req = 1'b1;
    exp_q.push_back(12'hA5C);
    tick(2);
    chk("single_ack_early", bus.Ack, 0);
    tick(1);
    chk("single_ack", bus.Ack, 1);
    chk("single_valid", bus.sample_valid, 1);
    chk("single_sample", bus.sample, 12'hA5C);
    bus.Req = 1'b0;
    tick(2);
    chk("single_ack_hold", bus.Ack, 1);
    tick(1);
    chk("single_ack_fall", bus.Ack, 0);
    tick(3);
    chk("single_one_pop", pops - p0, 1);

    // back-to-back transfers with ready held high
    max_lvl = 0;
    for (int i = 1; i <= 8; i++) send_word(W'(i), 1'b1);
    tick(4);
    chk("b2b_max_level", max_lvl, 1);
    chk("b2b_all_out", exp_q.size(), 0);
    rdy_force = 1'b0;

    // backpressure: 4 fill the buffer, the 5th stalls
    for (int i = 0; i < 4; i++) send_word(W'($urandom), 1'b0);
    chk("full_level", bus.level, 4);
    w = W'($urandom);
    bus.din = w;
    bus.Req = 1'b1;
    exp_q.push_back(w);
    tick(8);
    chk("full_no_ack", bus.Ack, 0);
    chk("full_level_hold", bus.level, 4);
    rdy_force = 1'b1;
    tick(1);
    rdy_force = 1'b0;
    chk("full_after_pop", bus.level, 3);
    tick(1);
    chk("full_5th_ack", bus.Ack, 1);
    chk("full_refill", bus.level, 4);
    bus.Req = 1'b0;
    wait_ack(1'b0, 20, "full_ack_fall");
    drain();

    // wrap-around with a slow consumer
    rdy_mode = 1'b1;
    for (int i = 0; i < 20; i++) send_word(W'($urandom), 1'b1);
    rdy_mode = 1'b0;
    drain();

    // reset while ACKED with two words buffered
    send_word(12'h111, 1'b0);
    bus.din = 12'h222;
    bus.Req = 1'b1;
    exp_q.push_back(12'h222);
    wait_ack(1'b1, 20, "rstmid_ack");
    chk("rstmid_level", bus.level, 2);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ack0", bus.Ack, 0);
    chk("rstmid_valid0", bus.sample_valid, 0);
    chk("rstmid_level0", bus.level, 0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    exp_q.push_back(12'h222);
    wait_ack(1'b1, 20, "rstmid_recapture");
    chk("rstmid_relevel", bus.level, 1);
    bus.Req = 1'b0;
    wait_ack(1'b0, 20, "rstmid_ack_fall");
    drain();

    // simultaneous push and pop at level 1
    send_word(12'h3C3, 1'b0);
    bus.din = 12'h4B4;
    bus.Req = 1'b1;
    exp_q.push_back(12'h4B4);
    tick(2);
    chk("simul_pre_level", bus.level, 1);
    rdy_force = 1'b1;
    tick(1);
    rdy_force = 1'b0;
    chk("simul_level", bus.level, 1);
    chk("simul_ack", bus.Ack, 1);
    chk("simul_sample", bus.sample, 12'h4B4);
    bus.Req = 1'b0;
    wait_ack(1'b0, 20, "simul_ack_fall");
    drain();

    tick(2);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/handshake_rx.md
Name: handshake_rx

Overview:
- Receive side of the 4-phase req/ack clock-domain crossing for 12-bit audio samples.
- Synchronises the incoming request and captures the held data word.
- Returns the acknowledge and buffers samples in a small first-word-fall-through FIFO.
- Presents samples to the downstream audio consumer (PWM/DAC driver) on a valid/ready interface.
- Sits in the consumer clock domain, directly downstream of the transmit-side handshake stage.

Parameters:
- WIDTH, 12: sample width in bits.
- SYNC_STAGES, 2: flops in the req_in synchroniser (minimum 2).
- FIFO_DEPTH, 4: output buffer entries (power of 2, minimum 2).

Ports:
- clk  in  1  consumer-domain clock.
- rst  in  1  reset; asynchronous, active-high.
- Req  in  1  request from the transmit domain; asynchronous to clk.
- din  in  WIDTH  sample data; held stable by the transmitter while Req is high.
- Ack  out  1  acknowledge to the transmit domain; registered, glitch-free.
- sample  out  WIDTH  head-of-FIFO sample.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer accepts sample this cycle.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: asynchronous, active-high. All synchroniser flops, state, pointers and level clear to 0. On reset: Ack=0, sample_valid=0, level=0, sample=0 (FIFO storage is not required to clear).
- Synchroniser: Req passes through SYNC_STAGES flops; req_s is the last stage. din is never synchronised. It is sampled only once req_s=1, which guarantees at least SYNC_STAGES cycles of settling.
- FSM states:
  - IDLE (Ack=0). If req_s=1 and FIFO not full: write din into FIFO, set Ack<=1 and go to ACKED. If the FIFO is full, stay in IDLE without acknowledging; the transmitter stalls and no sample is lost.
  - ACKED (Ack=1). Wait for req_s=0, then set Ack<=0 and go to IDLE. Exactly one write occurs per Req high phase.
- Latency: Req rises before edge N. With SYNC_STAGES=2, req_s=1 after edge N+1. Write and Ack rise on edge N+2, and sample_valid is visible in the cycle after edge N+2.
- Release latency: Ack falls SYNC_STAGES+1 edges after Req falls.
- FIFO behaviour:
  - First-word fall-through: sample = mem[rd_ptr] whenever sample_valid=1.
  - Pop on sample_valid & sample_ready.
  - Pointers carry one extra wrap bit. Full = MSBs differ and low bits equal. Empty = pointers equal.
  - Wrap-around is natural modulo 2*FIFO_DEPTH.
- Simultaneous push and pop: both occur and level is unchanged. The full check uses the registered level, so a pop coinciding with a full-state IDLE decision does not admit the push. Capture happens one cycle later. This is conservative and intentional.
- Pop when empty is ignored. sample_ready is don't-care while sample_valid=0.
- Reset mid-handshake: Ack drops to 0 immediately (asynchronously) and buffered samples are discarded. If Req is still high after reset, the same word is captured again (duplicate). This is accepted; both domains are reset together at system level.
- Illegal state encoding returns to IDLE with Ack=0.

Decomposition:
- Shared audio package holds:
  - WIDTH default (12).
  - State encodings (IDLE=1'b0, ACKED=1'b1).
  - The level-width function.
- The FIFO is a natural sub-module, fifo_fwft (params WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full, level). It is reusable by other audio paths.
- The synchroniser is inline.

Test Plan:
- Single transfer (reset released, sample_ready=1):
  - Stimulus: din=12'hA5C, raise Req.
  - Required: Ack=1 and sample=12'hA5C with sample_valid=1 three edges after the Req rise.
  - Then drop Req: Ack=0 three edges after the Req fall. Exactly one pop occurs.
- Back-to-back transfers:
  - Stimulus: drive 8 words (12'h001..12'h008) via a full 4-phase handshake model, with sample_ready=1.
  - Required: output order 001..008, no duplicates, level never exceeds 1.
- Backpressure/full:
  - Stimulus: sample_ready=0, send 5 words.
  - Required: first 4 acknowledged and level=4. The 5th Req stays unacknowledged (Ack=0).
  - Then raise sample_ready for one cycle: pop 1; the 5th word is captured 2 edges later and level returns to 4.
- Wrap-around:
  - Stimulus: 20 words, with sample_ready toggling 1-of-3 cycles.
  - Required: all 20 delivered in order; pointers wrap without loss.
- Reset mid-operation:
  - Stimulus: assert rst while in ACKED with level=2.
  - Required: Ack, sample_valid and level go to 0 without a clock edge.
  - If Req is still high after release, one recapture of the held din occurs.
- Simultaneous push/pop:
  - Stimulus: level=1, sample_ready=1, new Req arriving.
  - Required: push and pop on the same edge, level stays 1, data order preserved.
